// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared constants and fetch-state encoding for the CPU front end.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous prefetch FIFO with flush; flush beats push/pop.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Push,
  input  logic [WIDTH-1:0] PushData,
  input  logic             Pop,
  input  logic             Flush,
  output logic [CW-1:0]    Count,
  output logic [WIDTH-1:0] HeadData
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (Flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (Push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (Pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{(CW-1){1'b0}}, Push} - {{(CW-1){1'b0}}, Pop};
    end
  end

  // Storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge Clk) begin
    if (Push && !Flush) mem_q[wr_ptr_q] <= PushData;
  end

  assign Count    = count_q;
  assign HeadData = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : PC owner and single-outstanding instruction fetcher feeding IF/ID.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        Clk,
  input  logic        Rst_n,
  output logic        ImReq,
  output logic [31:0] ImAddr,
  input  logic        ImAck,
  input  logic [31:0] ImData,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  input  logic        IdReady,
  output logic        IfValid,
  output logic [31:0] IfInstr,
  output logic [31:0] IfPCPlus4
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  req_addr_q, req_addr_d;

  logic [CW-1:0] count;
  logic [63:0]   head;
  logic          push;
  logic          pop;
  logic [CW:0]   count_next;
  logic          room;
  logic [31:0]   target;
  logic [31:0]   req_plus4;

  assign target    = RedirectPC & 32'hFFFF_FFFC;
  assign req_plus4 = req_addr_q + 32'd4;

  assign IfValid = (count != '0) && !Redirect;
  assign pop     = IfValid && IdReady;
  assign push    = (state_q == ST_BUSY) && ImAck && !Redirect;

  always_comb begin
    count_next = '0;
    if (!Redirect) begin
      count_next = {1'b0, count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
    end
  end

  assign room = count_next < DEPTH_W;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Push     (push),
    .PushData ({ImData, req_plus4}),
    .Pop      (pop),
    .Flush    (Redirect),
    .Count    (count),
    .HeadData (head)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (Redirect) begin
          state_d    = ST_BUSY;
          req_addr_d = target;
        end else if (room) begin
          state_d    = ST_BUSY;
          req_addr_d = fetch_pc_q;
        end
      end
      ST_BUSY: begin
        if (Redirect) begin
          if (ImAck) begin
            req_addr_d = target;
          end else begin
            state_d = ST_DISCARD;
          end
        end else if (ImAck) begin
          fetch_pc_d = req_plus4;
          if (room) begin
            req_addr_d = req_plus4;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DISCARD: begin
        // A stale ack coinciding with a new redirect goes straight to the new target.
        if (ImAck) begin
          state_d    = ST_BUSY;
          req_addr_d = Redirect ? target : fetch_pc_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (Redirect) fetch_pc_d = target;
  end

  assign ImReq     = (state_q != ST_IDLE);
  assign ImAddr    = req_addr_q;
  assign IfInstr   = IfValid ? head[63:32] : NOP_INSTR;
  assign IfPCPlus4 = IfValid ? head[31:0]  : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed and randomized bench for fetch_unit against a stream model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        ImReq;
  logic [31:0] ImAddr;
  logic        ImAck = 1'b0;
  logic [31:0] ImData = 32'h0;
  logic        Redirect = 1'b0;
  logic [31:0] RedirectPC = 32'h0;
  logic        IdReady = 1'b0;
  logic        IfValid;
  logic [31:0] IfInstr;
  logic [31:0] IfPCPlus4;

  always #5 Clk = ~Clk;

  fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .ImReq      (ImReq),
    .ImAddr     (ImAddr),
    .ImAck      (ImAck),
    .ImData     (ImData),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .IdReady    (IdReady),
    .IfValid    (IfValid),
    .IfInstr    (IfInstr),
    .IfPCPlus4  (IfPCPlus4)
  );

  // Model: the decode side must see the sequential instruction stream starting at
  // the last redirect target (or reset PC); memory returns each word's own address.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pcp4;
  } ent_t;

  ent_t        q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] fetch_pc = 32'h0;
  int          epoch = 0;
  int          req_epoch = -1;
  bit          prev_req = 0;
  bit          prev_ack = 0;
  logic [31:0] prev_addr = 32'h0;
  int          wait_left = 0;
  int          lat_min = 0, lat_max = 0, rdy_pct = 100, redir_pct = 0;
  bit          force_redir = 0;
  logic [31:0] force_pc = 32'h0;
  int          starve = 0;
  int          pops = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    Rst_n    = 1'b0;
    ImAck    = 1'b0;
    Redirect = 1'b0;
    @(negedge Clk);
    Rst_n     = 1'b1;
    q.delete();
    fetch_pc  = 32'h0;
    epoch++;
    prev_req  = 0;
    prev_ack  = 0;
    wait_left = 0;
    starve    = 0;
    pops      = 0;
  endtask

  task automatic step();
    bit newreq;
    bit exp_valid;
    @(negedge Clk);
    newreq = ImReq && (!prev_req || prev_ack);
    if (newreq) begin
      wait_left = $urandom_range(lat_max, lat_min);
      req_epoch = epoch;
    end
    ImAck  = ImReq && (wait_left == 0);
    ImData = ImAck ? ImAddr : $urandom;
    if (force_redir) begin
      Redirect    = 1'b1;
      RedirectPC  = force_pc;
      force_redir = 0;
    end else begin
      Redirect   = ($urandom_range(99, 0) < redir_pct);
      RedirectPC = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                               : $urandom;
    end
    IdReady = ($urandom_range(99, 0) < rdy_pct);
    #1;
    exp_valid = (q.size() != 0) && !Redirect;
    chk("if_valid", 32'(IfValid), 32'(exp_valid));
    if (exp_valid) begin
      chk("if_instr", IfInstr, q[0].instr);
      chk("if_pcplus4", IfPCPlus4, q[0].pcp4);
    end else begin
      chk("nop_instr", IfInstr, 32'h0);
      chk("nop_pcplus4", IfPCPlus4, 32'h0);
    end
    if (ImReq && !newreq) chk("im_addr_hold", ImAddr, prev_addr);
    if (exp_valid && IdReady) begin
      void'(q.pop_front());
      pops++;
      starve = 0;
    end else begin
      starve++;
    end
    if (starve > 300) begin
      chk("progress_timeout", 32'(starve), 32'h0);
      starve = 0;
    end
    if (Redirect) begin
      q.delete();
      fetch_pc = RedirectPC & 32'hFFFF_FFFC;
      epoch++;
    end else if (ImAck && req_epoch == epoch) begin
      chk("fetch_addr", ImAddr, fetch_pc);
      q.push_back('{fetch_pc, fetch_pc + 32'd4});
      fetch_pc = fetch_pc + 32'd4;
      chk("fifo_overfill", 32'(q.size() <= DEPTH), 32'h1);
    end
    if (ImReq && !ImAck) wait_left--;
    prev_req  = ImReq;
    prev_ack  = ImAck;
    prev_addr = ImAddr;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  first_valid;
    bit  found;

    #2;
    chk("rst_imreq",   32'(ImReq), 32'h0);
    chk("rst_imaddr",  ImAddr,     32'h0);
    chk("rst_ifvalid", 32'(IfValid), 32'h0);
    chk("rst_ifinstr", IfInstr,    32'h0);
    chk("rst_pcplus4", IfPCPlus4,  32'h0);

    // Zero-wait streaming
    lat_min = 0; lat_max = 0; rdy_pct = 100; redir_pct = 0;
    do_reset();
    step();
    chk("first_imreq", 32'(ImReq), 32'h1);
    chk("first_imaddr", ImAddr, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("stream_instr", IfInstr, 32'(4 * (k - 1)));
      chk("stream_pcplus4", IfPCPlus4, 32'(4 * k));
      chk("stream_imaddr", ImAddr, 32'(4 * k));
    end

    // Three wait cycles per access
    lat_min = 3; lat_max = 3;
    do_reset();
    first_valid = -1;
    for (int s = 1; s <= 20; s++) begin
      step();
      if (IfValid && first_valid < 0) first_valid = s;
    end
    chk("lat3_first_valid", 32'(first_valid), 32'd5);
    chk("lat3_delivered", 32'(pops), 32'd4);

    // Decode stall with PC 8 at the head
    lat_min = 0; lat_max = 0;
    do_reset();
    for (int s = 1; s <= 3; s++) step();
    rdy_pct = 0;
    for (int s = 4; s <= 8; s++) begin
      step();
      chk("stall_instr", IfInstr, 32'h8);
      chk("stall_pcplus4", IfPCPlus4, 32'hC);
      if (s >= 5) chk("stall_imreq_low", 32'(ImReq), 32'h0);
    end
    rdy_pct = 100;
    step(); chk("resume_instr0", IfInstr, 32'h8);
    step(); chk("resume_instr1", IfInstr, 32'hC);
    step(); chk("resume_instr2", IfInstr, 32'h10);

    // Redirect while a slow request to 0x10 is outstanding
    lat_min = 3; lat_max = 3;
    do_reset();
    found = 0;
    for (int s = 0; s < 40 && !found; s++) begin
      step();
      if (ImReq && ImAddr == 32'h10) found = 1;
    end
    chk("reach_req_0x10", 32'(found), 32'h1);
    force_redir = 1; force_pc = 32'h103;
    step();
    found = 0;
    for (int s = 0; s < 20 && !found; s++) begin
      step();
      if (ImReq && ImAddr !== 32'h10) found = 1;
    end
    chk("discard_new_req", 32'(found), 32'h1);
    chk("discard_next_addr", ImAddr, 32'h100);
    found = 0;
    for (int s = 0; s < 20 && !found; s++) begin
      step();
      if (IfValid) found = 1;
    end
    chk("discard_valid_seen", 32'(found), 32'h1);
    chk("discard_first_instr", IfInstr, 32'h100);

    // Redirect coinciding with an ack
    lat_min = 0; lat_max = 0;
    do_reset();
    step(); step(); step();
    force_redir = 1; force_pc = 32'h200;
    step();
    chk("redir_ack_ifvalid", 32'(IfValid), 32'h0);
    step();
    chk("redir_ack_imreq", 32'(ImReq), 32'h1);
    chk("redir_ack_imaddr", ImAddr, 32'h200);
    chk("redir_ack_empty", 32'(IfValid), 32'h0);
    step();
    chk("redir_ack_valid", 32'(IfValid), 32'h1);
    chk("redir_ack_instr", IfInstr, 32'h200);

    // Redirect with a full FIFO and decode ready
    rdy_pct = 0;
    do_reset();
    step(); step(); step();
    chk("full_imreq_low", 32'(ImReq), 32'h0);
    rdy_pct = 100;
    force_redir = 1; force_pc = 32'h300;
    step();
    chk("full_redir_ifvalid", 32'(IfValid), 32'h0);
    step();
    chk("full_redir_empty", 32'(IfValid), 32'h0);
    chk("full_redir_imreq", 32'(ImReq), 32'h1);
    chk("full_redir_imaddr", ImAddr, 32'h300);

    // Asynchronous reset in the middle of a request
    lat_min = 3; lat_max = 3;
    do_reset();
    step(); step();
    chk("pre_rst_imreq", 32'(ImReq), 32'h1);
    #2 Rst_n = 1'b0;
    #1;
    chk("arst_imreq",   32'(ImReq), 32'h0);
    chk("arst_imaddr",  ImAddr,     32'h0);
    chk("arst_ifvalid", 32'(IfValid), 32'h0);
    chk("arst_ifinstr", IfInstr,    32'h0);
    chk("arst_pcplus4", IfPCPlus4,  32'h0);
    lat_min = 0; lat_max = 0;
    do_reset();
    step();
    chk("restart_imreq", 32'(ImReq), 32'h1);
    chk("restart_imaddr", ImAddr, 32'h0);

    // Randomized traffic
    lat_min = 0; lat_max = 3; rdy_pct = 70; redir_pct = 8;
    do_reset();
    for (int s = 0; s < 2500; s++) step();
    lat_min = 0; lat_max = 5; rdy_pct = 40; redir_pct = 3;
    for (int s = 0; s < 2500; s++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
